// File: rtl/wishbone_interconnect_n.sv
// Single-master, N-slave Wishbone classic interconnect.
// The top address byte selects one slave window. Requests and responses are
// registered. Unmapped addresses and slaves that never ack return a bus error.
// Slave interrupts are masked and OR-ed into one registered line.
module wishbone_interconnect_n #(
    parameter int                    NUM_SLAVES = 4,
    parameter int                    TIMEOUT    = 255,
    parameter logic [NUM_SLAVES-1:0] INT_MASK   = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_we_i,
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    input  logic [3:0]                 m_sel_i,
    input  logic [31:0]                m_adr_i,
    input  logic [31:0]                m_dat_i,
    output logic [31:0]                m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic                       m_int_o,
    output logic [NUM_SLAVES-1:0]      s_we_o,
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    output logic [3:0]                 s_sel_o,
    output logic [31:0]                s_adr_o,
    output logic [31:0]                s_dat_o,
    input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [NUM_SLAVES-1:0]      s_int_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [15:0]           cnt;
    logic [NUM_SLAVES-1:0] dec_oh;
    logic                  mapped;
    logic                  ack_hit;
    logic [31:0]           rd_data;

    // Decode the incoming window byte into a one-hot slave select.
    always_comb begin
        dec_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec_oh[i] = (m_adr_i[31:24] == 8'(i));
        end
        mapped = |dec_oh;
    end

    // The registered cyc vector identifies the active slave. Its ack and read
    // data are the only ones that matter; all other acks are masked off.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_cyc_o[i]) begin
                rd_data = rd_data | s_dat_i[i*32 +: 32];
            end
        end
        ack_hit = |(s_ack_i & s_cyc_o);
    end

    // Transfer sequencing: request latch, slave strobe, response and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            m_dat_o <= '0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_int_o <= 1'b0;
            s_we_o  <= '0;
            s_cyc_o <= '0;
            s_stb_o <= '0;
            s_sel_o <= '0;
            s_adr_o <= '0;
            s_dat_o <= '0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_int_o <= |(s_int_i & INT_MASK);
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_adr_o <= {8'h00, m_adr_i[23:0]};
                        s_sel_o <= m_sel_i;
                        s_dat_o <= m_dat_i;
                        cnt     <= '0;
                        if (mapped) begin
                            state   <= BUSY;
                            s_cyc_o <= dec_oh;
                            s_stb_o <= dec_oh;
                            s_we_o  <= m_we_i ? dec_oh : '0;
                        end else begin
                            state   <= ERR;
                            m_err_o <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 16'd1;
                    if (!m_cyc_i) begin
                        // Master abort: release the slave silently.
                        state   <= IDLE;
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        s_we_o  <= '0;
                    end else if (ack_hit) begin
                        // Read data is captured only for reads; writes keep the old value.
                        if (~|s_we_o) begin
                            m_dat_o <= rd_data;
                        end
                        state   <= DONE;
                        m_ack_o <= 1'b1;
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        s_we_o  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ERR;
                        m_err_o <= 1'b1;
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        s_we_o  <= '0;
                    end
                end
                default: begin
                    // DONE and ERR last one cycle; the still-visible request is not re-decoded.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// Testbench for wishbone_interconnect_n: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model.
module tb_wishbone_interconnect_n;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [NS-1:0] MASK = 4'b0101;

    logic          clk;
    logic          rst;
    logic          m_we_i, m_cyc_i, m_stb_i;
    logic [3:0]    m_sel_i;
    logic [31:0]   m_adr_i, m_dat_i;
    logic [31:0]   m_dat_o;
    logic          m_ack_o, m_err_o, m_int_o;
    logic [NS-1:0] s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]    s_sel_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [32*NS-1:0] s_dat_i;
    logic [NS-1:0] s_ack_i, s_int_i;

    int n_cmp = 0;
    int n_bad = 0;

    wishbone_interconnect_n #(
        .NUM_SLAVES(NS),
        .TIMEOUT   (TO),
        .INT_MASK  (MASK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_we_i (m_we_i),
        .m_cyc_i(m_cyc_i),
        .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .m_int_o(m_int_o),
        .s_we_o (s_we_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),
        .s_int_i(s_int_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: which slave is being served, how many strobe
    // cycles it has had, and whether a one-cycle response is being shown.
    bit          model_on = 1'b0;
    int          cur  = -1;
    int          age  = 0;
    int          resp = 0;
    int          slave;
    logic        e_ack, e_err, e_int, e_we;
    logic [31:0] e_dat, e_adr, e_sdat;
    logic [3:0]  e_sel;

    // Advance the model on each rising edge with the inputs the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            cur = -1; age = 0; resp = 0;
            e_ack = 0; e_err = 0; e_int = 0; e_we = 0;
            e_dat = '0; e_adr = '0; e_sdat = '0; e_sel = '0;
        end else begin
            e_int = |(s_int_i & MASK);
            e_ack = 0;
            e_err = 0;
            if (resp != 0) begin
                resp = 0;
            end else if (cur < 0) begin
                if (m_cyc_i && m_stb_i) begin
                    slave  = int'(m_adr_i[31:24]);
                    e_adr  = {8'h00, m_adr_i[23:0]};
                    e_sel  = m_sel_i;
                    e_sdat = m_dat_i;
                    e_we   = m_we_i;
                    if (slave < NS) begin
                        cur = slave;
                        age = 1;
                    end else begin
                        resp  = 2;
                        e_err = 1;
                    end
                end
            end else begin
                if (!m_cyc_i) begin
                    cur = -1;
                end else if (s_ack_i[cur]) begin
                    if (!e_we) e_dat = s_dat_i[cur*32 +: 32];
                    resp  = 1;
                    e_ack = 1;
                    cur   = -1;
                end else if (age == TO) begin
                    resp  = 2;
                    e_err = 1;
                    cur   = -1;
                end else begin
                    age++;
                end
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        logic [NS-1:0] e_stb;
        logic [NS-1:0] e_swe;
        if (model_on) begin
            e_stb = (cur >= 0) ? NS'(1 << cur) : '0;
            e_swe = e_we ? e_stb : '0;
            check("m_ack", 32'(m_ack_o), 32'(e_ack));
            check("m_err", 32'(m_err_o), 32'(e_err));
            check("m_int", 32'(m_int_o), 32'(e_int));
            check("m_dat", m_dat_o, e_dat);
            check("s_cyc", 32'(s_cyc_o), 32'(e_stb));
            check("s_stb", 32'(s_stb_o), 32'(e_stb));
            check("s_we",  32'(s_we_o),  32'(e_swe));
            check("s_adr", s_adr_o, e_adr);
            check("s_sel", 32'(s_sel_o), 32'(e_sel));
            check("s_dat", s_dat_o, e_sdat);
        end
    end

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic idle_master();
        m_cyc_i = 0; m_stb_i = 0; m_we_i = 0;
    endtask

    task automatic request(input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
        m_cyc_i = 1; m_stb_i = 1; m_we_i = we;
        m_adr_i = adr; m_sel_i = sel; m_dat_i = dat;
    endtask

    int ack_pct;
    logic [7:0] top;

    initial begin
        rst = 1; s_dat_i = '0; s_ack_i = '0; s_int_i = '0;
        request(1'b0, 32'h0200_0000, 4'hF, 32'h0);

        // Reset held two cycles with a request pending.
        nc(); nc();
        check("rst_ack", 32'(m_ack_o), 32'h0);
        check("rst_err", 32'(m_err_o), 32'h0);
        check("rst_stb", 32'(s_stb_o), 32'h0);
        check("rst_dat", m_dat_o, 32'h0);
        rst = 0;
        idle_master();
        nc();

        // Read slave 2, ack three cycles after the strobe starts.
        request(1'b0, 32'h0200_0010, 4'hF, 32'h0);
        nc();
        check("rd_stb_c1", 32'(s_stb_o), 32'h4);
        check("rd_adr_c1", s_adr_o, 32'h0000_0010);
        nc();
        nc();
        s_ack_i = 4'b0100; s_dat_i[95:64] = 32'hDEAD_BEEF;
        nc();
        check("rd_ack_c4", 32'(m_ack_o), 32'h1);
        check("rd_dat_c4", m_dat_o, 32'hDEAD_BEEF);
        check("rd_stb_c4", 32'(s_stb_o), 32'h0);
        idle_master(); s_ack_i = '0;
        nc();
        check("rd_ack_c5", 32'(m_ack_o), 32'h0);

        // Write slave 0 with immediate ack.
        request(1'b1, 32'h0000_0000, 4'b0011, 32'h1234_5678);
        nc();
        check("wr_we_c1",  32'(s_we_o), 32'h1);
        check("wr_sel_c1", 32'(s_sel_o), 32'h3);
        check("wr_dat_c1", s_dat_o, 32'h1234_5678);
        s_ack_i = 4'b0001;
        nc();
        check("wr_ack_c2", 32'(m_ack_o), 32'h1);
        check("wr_mdat_c2", m_dat_o, 32'hDEAD_BEEF);
        idle_master(); s_ack_i = '0;
        nc();

        // Unmapped window.
        request(1'b0, 32'h0700_0000, 4'hF, 32'h0);
        nc();
        check("um_err_c1", 32'(m_err_o), 32'h1);
        check("um_cyc_c1", 32'(s_cyc_o), 32'h0);
        idle_master();
        nc();
        check("um_err_c2", 32'(m_err_o), 32'h0);
        check("um_cyc_c2", 32'(s_cyc_o), 32'h0);

        // Watchdog: no ack, then ack on the last allowed cycle.
        for (int pass = 0; pass < 2; pass++) begin
            request(1'b0, 32'h0100_0000, 4'hF, 32'h0);
            s_dat_i[63:32] = 32'hCAFE_0001;
            for (int k = 1; k <= TO; k++) begin
                nc();
                check("to_stb", 32'(s_stb_o), 32'h2);
                check("to_err_early", 32'(m_err_o), 32'h0);
                if (pass == 1 && k == TO) s_ack_i = 4'b0010;
            end
            nc();
            check("to_stb_end", 32'(s_stb_o), 32'h0);
            check("to_err_end", 32'(m_err_o), (pass == 0) ? 32'h1 : 32'h0);
            check("to_ack_end", 32'(m_ack_o), (pass == 0) ? 32'h0 : 32'h1);
            idle_master(); s_ack_i = '0;
            nc();
        end
        check("to_rdat", m_dat_o, 32'hCAFE_0001);

        // Master abort in cycle 3.
        request(1'b0, 32'h0300_0004, 4'hF, 32'h0);
        nc(); nc(); nc();
        check("ab_stb_c3", 32'(s_stb_o), 32'h8);
        idle_master();
        nc();
        check("ab_stb_c4", 32'(s_stb_o), 32'h0);
        check("ab_resp_c4", {30'h0, m_ack_o, m_err_o}, 32'h0);
        nc();
        check("ab_resp_c5", {30'h0, m_ack_o, m_err_o}, 32'h0);

        // Interrupt masking.
        s_int_i = 4'b0010;
        nc(); nc();
        check("int_masked", 32'(m_int_o), 32'h0);
        s_int_i = 4'b0100;
        check("int_lag", 32'(m_int_o), 32'h0);
        nc();
        check("int_pass", 32'(m_int_o), 32'h1);
        s_int_i = '0;
        nc(); nc();
        check("int_clear", 32'(m_int_o), 32'h0);

        // Randomized traffic, checked continuously by the model.
        ack_pct = 25;
        for (int c = 0; c < 6000; c++) begin
            nc();
            if (c % 400 == 0) begin
                case ($urandom % 4)
                    0: ack_pct = 0;
                    1: ack_pct = 6;
                    2: ack_pct = 25;
                    default: ack_pct = 60;
                endcase
            end
            rst = ($urandom % 300 == 0);
            s_int_i = NS'($urandom);
            s_dat_i = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < NS; i++) s_ack_i[i] = ($urandom % 100 < ack_pct);
            if (!m_cyc_i || m_ack_o || m_err_o || ($urandom % 25 == 0)) begin
                if ($urandom % 3 != 0) begin
                    top = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom % 5);
                    request(1'($urandom), {top, 24'($urandom)}, 4'($urandom), $urandom);
                end else begin
                    m_cyc_i = ($urandom % 4 == 0);
                    m_stb_i = 0;
                end
            end
        end
        rst = 0;
        idle_master();
        nc(); nc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_interconnect_n.md
# wishbone_interconnect_n

Parametrised single-master, N-slave Wishbone classic interconnect with registered address decode, per-transaction slave latching, a no-ack watchdog and bus-error reporting. It sits between the host-side Wishbone master and up to 256 peripheral slaves, each occupying one 16 MB window selected by `m_adr_i[31:24]`. Unlike the previous purely combinational router, it:
- registers every request and response;
- returns `m_err_o` for unmapped addresses and for slaves that never ack;
- aggregates slave interrupts through a mask.

## Interface
Parameters:
- `NUM_SLAVES`, 4 — number of slave ports, 1..256; slave i decodes at `m_adr_i[31:24] == i`.
- `TIMEOUT`, 255 — cycles in BUSY without ack before abort, 1..65535.
- `INT_MASK`, all ones (`NUM_SLAVES` bits) — bit i enables `s_int_i[i]` into `m_int_o`.

Ports:
- `clk` in 1 — only clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `m_we_i`, `m_cyc_i`, `m_stb_i` in 1 each — master control.
- `m_sel_i` in 4 — byte selects.
- `m_adr_i` in 32 — address; [31:24] slave select, [23:0] slave offset.
- `m_dat_i` in 32 — write data.
- `m_dat_o` out 32 — read data, registered.
- `m_ack_o` out 1 — one-cycle ack, registered.
- `m_err_o` out 1 — one-cycle bus error, registered.
- `m_int_o` out 1 — registered OR of masked slave interrupts.
- `s_we_o`, `s_cyc_o`, `s_stb_o` out `NUM_SLAVES` each — per-slave control, one-hot or zero.
- `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32 — shared, registered; `s_adr_o` = {8'h00, latched `m_adr_i[23:0]`}.
- `s_dat_i` in 32*`NUM_SLAVES` — slave i read data at bits [32i+31:32i].
- `s_ack_i`, `s_int_i` in `NUM_SLAVES` each.

## Operation
- States:
  - IDLE — no slave selected.
  - BUSY — slave `idx` selected, waiting for ack.
  - DONE — `m_ack_o` = 1.
  - ERR — `m_err_o` = 1.
- IDLE, `m_cyc_i & m_stb_i` sampled:
  - Latch `idx` = `m_adr_i[31:24]`, plus we/sel/adr/dat.
  - If `idx < NUM_SLAVES`: go to BUSY, clear timeout counter.
  - Else go to ERR; no slave strobed.
- BUSY:
  - `s_cyc_o[idx]` = `s_stb_o[idx]` = 1, `s_we_o[idx]` = latched we; all other slave bits 0.
  - Counter increments each BUSY cycle.
- BUSY exits, in priority order:
  1. `m_cyc_i` = 0 (master abort) → IDLE; no ack or err.
  2. `s_ack_i[idx]` = 1 → latch `s_dat_i[idx]` into `m_dat_o`, go to DONE.
  3. Counter == `TIMEOUT`-1 → ERR.
- Acks from non-selected slaves are ignored.
- DONE and ERR each last exactly one cycle, then → IDLE.
- The request still visible during DONE/ERR is not re-decoded. IDLE re-arms on the next cycle, so a master holding `stb` after ack starts a new transfer; masters must drop `stb` on ack per Wishbone classic.
- `m_dat_o` holds its last value until the next successful read. Writes and errors leave it unchanged.
- `m_int_o` <= |(`s_int_i` & `INT_MASK`) every cycle, independent of state.

## Timing
- Reset: state IDLE; counter 0; all outputs 0 (`m_dat_o`, `m_ack_o`, `m_err_o`, `m_int_o`, all `s_*_o`).
- `rst` mid-transfer: slave `cyc`/`stb` drop on the edge after `rst` is sampled. No ack/err is issued and the transfer is lost.
- Cycle 0 = first cycle `m_cyc_i & m_stb_i` is high in IDLE:
  - Slave strobe high from cycle 1.
  - Slave ack in cycle n (n ≥ 1) → slave strobe low and `m_ack_o` high in cycle n+1.
  - Minimum latency cycle 0 → `m_ack_o` = 2 cycles.
- Unmapped address: `m_err_o` high in cycle 1 only.
- No ack: strobe high cycles 1..`TIMEOUT`, `m_err_o` high in cycle `TIMEOUT`+1, strobe low from cycle `TIMEOUT`+1.
- Ack in the same cycle the counter reaches `TIMEOUT`-1: ack wins, response is `m_ack_o`.
- Back-to-back: next request is accepted at the earliest in cycle n+2 (the IDLE cycle after DONE).
- `m_int_o` lags `s_int_i` by one cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `m_stb_i` high → all outputs 0, state IDLE, no slave strobed.
- Read slave 2: `m_adr_i` = 32'h0200_0010, slave 2 acks 3 cycles after strobe with 32'hDEAD_BEEF → `s_adr_o` = 32'h0000_0010, only `s_stb_o[2]` high, `m_ack_o` for one cycle with `m_dat_o` = 32'hDEAD_BEEF, total latency 4 cycles.
- Write slave 0 with `m_sel_i` = 4'b0011 and `m_dat_i` = 32'h1234_5678, immediate ack → `s_we_o[0]` = 1, `s_sel_o` = 4'b0011, `s_dat_o` = 32'h1234_5678, `m_ack_o` in cycle 2, `m_dat_o` unchanged.
- Unmapped: `NUM_SLAVES` = 4, `m_adr_i` = 32'h0700_0000 → `m_err_o` in cycle 1, `s_cyc_o` = 0 throughout.
- Timeout: `TIMEOUT` = 8, slave 1 never acks → `s_stb_o[1]` high cycles 1..8, `m_err_o` in cycle 9. Repeat with ack in cycle 8 → `m_ack_o` in cycle 9, no err.
- Abort and interrupts: drop `m_cyc_i` in cycle 3 of a BUSY transfer → strobe low in cycle 4, no ack/err. With `INT_MASK` = 4'b0101: raise `s_int_i[1]` → `m_int_o` stays 0; raise `s_int_i[2]` → `m_int_o` high one cycle later.
